// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and widths for the unified-memory port arbiter.
package mem_port_arbiter_pkg;
  localparam int DEF_WORD_SIZE = 32;
  localparam int DEF_ADDR_SIZE = 32;
  localparam int TO_W          = 8;   // holds TIMEOUT up to 255
  localparam int STARVE_W      = 4;   // holds MAX_STARVE up to 15

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

  function automatic logic is_busy(arb_state_e s);
    return (s == ARB_BUSY_I) || (s == ARB_BUSY_D);
  endfunction
endpackage

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// Loadable up-counter; term flags the increment that brings the count to LIMIT.
module arb_timeout_cnt #(
  parameter int W     = 8,
  parameter int LIMIT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         inc,
  output logic         term
);
  logic [W-1:0] cnt;

  assign term = inc && (cnt == W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (ld)  cnt <= ld_val;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one single-port memory: data first,
// fetch guaranteed after MAX_STARVE data grants, per-access timeout, halt drain.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int MAX_STARVE = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_ack,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_ack,
  output logic                 d_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  input  logic                 halt_req,
  output logic                 drained
);
  arb_state_e          state, state_nx;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_i, grant_d, fin_ack, fin_to;
  logic                to_inc, to_term, starved;

  assign to_inc  = is_busy(state) && !mem_ack;
  assign starved = (starve_cnt == STARVE_W'(MAX_STARVE));
  assign drained = halt_req && (state == ARB_IDLE) && !(if_ack || if_err || d_ack || d_err);

  arb_timeout_cnt #(.W(TO_W), .LIMIT(TIMEOUT)) u_to (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (grant_i || grant_d),
    .ld_val ('0),
    .inc    (to_inc),
    .term   (to_term)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    fin_ack  = 1'b0;
    fin_to   = 1'b0;
    unique case (state)
      ARB_IDLE: if (!halt_req) begin
        if (d_req && !(if_req && starved)) begin
          grant_d  = 1'b1;
          state_nx = ARB_BUSY_D;
        end else if (if_req) begin
          grant_i  = 1'b1;
          state_nx = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // an ack on the terminal cycle still completes normally
        if (mem_ack) begin
          fin_ack  = 1'b1;
          state_nx = ARB_RESP;
        end else if (to_term) begin
          fin_to   = 1'b1;
          state_nx = ARB_RESP;
        end
      end
      ARB_RESP: state_nx = ARB_IDLE;
      default:  state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d && if_req && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      if_err <= 1'b0;
      d_ack  <= 1'b0;
      d_err  <= 1'b0;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
      end else if (grant_i) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end
      if (fin_ack || fin_to) mem_req <= 1'b0;
      if (fin_ack) begin
        if (state == ARB_BUSY_I) begin
          if_ack   <= 1'b1;
          if_rdata <= mem_rdata;
        end else begin
          d_ack <= 1'b1;
          if (!mem_we) d_rdata <= mem_rdata;
        end
      end
      if (fin_to) begin
        if (state == ARB_BUSY_I) if_err <= 1'b1;
        else                     d_err  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: transaction-level reference model checked every cycle, plus pinned literals.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;
  localparam int TMO  = 64;
  localparam int NLIT = 128;
  localparam int ID_MEM_REQ = 0, ID_MEM_WE = 1, ID_MEM_ADDR = 2, ID_MEM_WDATA = 3, ID_IF_ACK = 4,
                 ID_IF_RDATA = 5, ID_D_ACK = 6, ID_D_ERR = 7, ID_D_RDATA = 8, ID_DRAINED = 9;

  logic clk = 1'b0, rst_n = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, halt_req = 1'b0, mem_ack = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic if_ack, if_err, d_ack, d_err, mem_req, mem_we, drained;

  mem_port_arbiter #(.WORD_SIZE(32), .ADDR_SIZE(32), .MAX_STARVE(MAXS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ack(if_ack), .if_err(if_err), .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .halt_req(halt_req), .drained(drained)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // memory: acks mem_lat cycles after mem_req rises (never if negative)
  logic [31:0] mem_a [logic [31:0]];
  int mem_lat = 0, late_ack_cyc = -1, wcnt = 0;
  function automatic logic [31:0] rd(logic [31:0] a);
    return mem_a.exists(a) ? mem_a[a] : (a ^ 32'hA5A5_0000);
  endfunction
  initial begin
    mem_a[32'h10] = 32'h8C22_0004;
    mem_a[32'h20] = 32'h1234_5678;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rst_n || !mem_req) wcnt = 0;
      else if (mem_lat >= 0 && wcnt == mem_lat) begin
        mem_ack = 1'b1;
        if (mem_we) mem_a[mem_addr] = mem_wdata;
        else        mem_rdata = rd(mem_addr);
        wcnt = 1000;
      end else wcnt++;
      if (cyc == late_ack_cyc) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // reference model: one outstanding transaction, then one response cycle
  bit m_busy = 0, m_resp = 0, m_err = 0, m_own_d = 0, m_we = 0;
  int m_age = 0, m_starve = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_busy = 0; m_resp = 0; m_err = 0; m_own_d = 0; m_we = 0; m_age = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0; m_resp = 1; m_err = 0;
        if (!m_own_d)  m_if_rdata = mem_rdata;
        else if (!m_we) m_d_rdata = mem_rdata;
      end else begin
        m_age++;
        if (m_age == TMO) begin m_busy = 0; m_resp = 1; m_err = 1; end
      end
    end else if (m_resp) begin
      m_resp = 0;
    end else if (!halt_req && (d_req || if_req)) begin
      m_own_d = d_req && !(if_req && m_starve == MAXS);
      if (m_own_d) begin
        if (if_req && m_starve < MAXS) m_starve++;
        m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
      end else begin
        m_starve = 0; m_we = 0; m_addr = if_addr;
      end
      m_busy = 1; m_age = 0;
    end
  end

  // literal expectations posted by the stimulus, checked by the compare process
  int lit_n = 0;
  int lit_c [NLIT];
  int lit_id [NLIT];
  logic [31:0] lit_v [NLIT];
  string lit_nm [NLIT];
  bit lit_done [NLIT];
  task automatic expect_at(int c, int id, logic [31:0] v, string nm);
    if (lit_n < NLIT) begin
      lit_c[lit_n] = c; lit_id[lit_n] = id; lit_v[lit_n] = v; lit_nm[lit_n] = nm;
      lit_n++;
    end
  endtask

  function automatic logic [31:0] actual(int id);
    case (id)
      ID_MEM_REQ:   return {31'd0, mem_req};
      ID_MEM_WE:    return {31'd0, mem_we};
      ID_MEM_ADDR:  return mem_addr;
      ID_MEM_WDATA: return mem_wdata;
      ID_IF_ACK:    return {31'd0, if_ack};
      ID_IF_RDATA:  return if_rdata;
      ID_D_ACK:     return {31'd0, d_ack};
      ID_D_ERR:     return {31'd0, d_err};
      ID_D_RDATA:   return d_rdata;
      default:      return {31'd0, drained};
    endcase
  endfunction

  int n_vec = 0, n_miss = 0;
  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    cmp("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
    cmp("if_ack", {31'd0, if_ack}, {31'd0, m_resp && !m_err && !m_own_d});
    cmp("if_err", {31'd0, if_err}, {31'd0, m_resp && m_err && !m_own_d});
    cmp("d_ack", {31'd0, d_ack}, {31'd0, m_resp && !m_err && m_own_d});
    cmp("d_err", {31'd0, d_err}, {31'd0, m_resp && m_err && m_own_d});
    cmp("if_rdata", if_rdata, m_if_rdata);
    cmp("d_rdata", d_rdata, m_d_rdata);
    cmp("drained", {31'd0, drained}, {31'd0, halt_req && !m_busy && !m_resp});
    if (m_busy) begin
      cmp("mem_we", {31'd0, mem_we}, {31'd0, m_we});
      cmp("mem_addr", mem_addr, m_addr);
      if (m_own_d && m_we) cmp("mem_wdata", mem_wdata, m_wdata);
    end
    for (int i = 0; i < lit_n; i++)
      if (!lit_done[i] && lit_c[i] <= cyc) begin
        lit_done[i] = 1'b1;
        cmp(lit_nm[i], actual(lit_id[i]), lit_v[i]);
      end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // waits for the port's ack/err, then drops its request
  task automatic wait_resp(bit dside, int budget);
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (dside ? (d_ack || d_err) : (if_ack || if_err)) begin
        if (dside) d_req = 1'b0; else if_req = 1'b0;
        return;
      end
    end
    expect_at(cyc, dside ? ID_D_ACK : ID_IF_ACK, 32'd1, "resp_wait");
    if (dside) d_req = 1'b0; else if_req = 1'b0;
  endtask

  initial begin
    int t0;
    tick(3);
    expect_at(cyc, ID_MEM_REQ, 0, "rst_mem_req");
    expect_at(cyc, ID_D_RDATA, 0, "rst_d_rdata");
    expect_at(cyc, ID_IF_RDATA, 0, "rst_if_rdata");
    rst_n = 1'b1;
    tick(2);

    // fetch only, two wait states
    mem_lat = 2; if_addr = 32'h10; if_req = 1'b1; t0 = cyc;
    expect_at(t0, ID_MEM_REQ, 0, "s1_req_c0");
    expect_at(t0 + 1, ID_MEM_REQ, 1, "s1_req_c1");
    expect_at(t0 + 1, ID_MEM_WE, 0, "s1_we");
    expect_at(t0 + 1, ID_MEM_ADDR, 32'h10, "s1_addr");
    expect_at(t0 + 3, ID_IF_ACK, 0, "s1_ack_c3");
    expect_at(t0 + 4, ID_IF_ACK, 1, "s1_ack_c4");
    expect_at(t0 + 4, ID_IF_RDATA, 32'h8C22_0004, "s1_rdata");
    expect_at(t0 + 4, ID_D_ACK, 0, "s1_d_ack");
    wait_resp(1'b0, 12);

    // simultaneous requests, data write wins, fetch right after RESP
    tick(1);
    mem_lat = 0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h20; t0 = cyc;
    expect_at(t0 + 1, ID_MEM_WE, 1, "s2_we");
    expect_at(t0 + 1, ID_MEM_ADDR, 32'h40, "s2_addr");
    expect_at(t0 + 1, ID_MEM_WDATA, 32'hDEAD_BEEF, "s2_wdata");
    expect_at(t0 + 2, ID_D_ACK, 1, "s2_d_ack");
    expect_at(t0 + 4, ID_MEM_ADDR, 32'h20, "s2_f_addr");
    expect_at(t0 + 5, ID_IF_ACK, 1, "s2_if_ack");
    expect_at(t0 + 5, ID_IF_RDATA, 32'h1234_5678, "s2_if_rdata");
    wait_resp(1'b1, 10);
    wait_resp(1'b0, 10);
    d_we = 1'b0;

    // starvation: four data reads, then the fetch, then data wins again
    tick(1);
    mem_lat = 1; if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_addr = 32'h100; t0 = cyc;
    for (int k = 0; k < 4; k++) expect_at(t0 + 3 + 4 * k, ID_D_ACK, 1, "s3_d_ack");
    expect_at(t0 + 15, ID_IF_ACK, 0, "s3_if_early");
    expect_at(t0 + 17, ID_MEM_ADDR, 32'h30, "s3_f_addr");
    expect_at(t0 + 17, ID_MEM_WE, 0, "s3_f_we");
    expect_at(t0 + 19, ID_IF_ACK, 1, "s3_if_ack");
    expect_at(t0 + 19, ID_D_ACK, 0, "s3_d_quiet");
    expect_at(t0 + 21, ID_MEM_ADDR, 32'h110, "s3_d5_addr");
    while (cyc < t0 + 21) begin
      tick(1);
      if (d_ack)  d_addr = d_addr + 32'd4;
      if (if_ack) if_addr = 32'h34;
    end
    wait_resp(1'b1, 20);
    wait_resp(1'b0, 20);

    // timeout with a late ack afterwards
    tick(1);
    mem_lat = -1; d_req = 1'b1; d_addr = 32'h200; t0 = cyc; late_ack_cyc = t0 + 66;
    expect_at(t0 + 1, ID_MEM_REQ, 1, "s4_req_first");
    expect_at(t0 + 64, ID_MEM_REQ, 1, "s4_req_last");
    expect_at(t0 + 65, ID_MEM_REQ, 0, "s4_req_drop");
    expect_at(t0 + 65, ID_D_ERR, 1, "s4_d_err");
    expect_at(t0 + 65, ID_D_ACK, 0, "s4_no_ack");
    expect_at(t0 + 65, ID_D_RDATA, 32'hA5A5_0110, "s4_rdata_hold");
    expect_at(t0 + 67, ID_D_ACK, 0, "s4_late_ack");
    expect_at(t0 + 67, ID_D_RDATA, 32'hA5A5_0110, "s4_late_rdata");
    wait_resp(1'b1, 80);
    tick(4);

    // halt raised mid-read: read completes, fetch blocked until halt drops
    tick(1);
    mem_lat = 3; d_req = 1'b1; d_addr = 32'h300; t0 = cyc;
    expect_at(t0 + 3, ID_DRAINED, 0, "s5_drn_busy");
    expect_at(t0 + 5, ID_D_ACK, 1, "s5_d_ack");
    expect_at(t0 + 5, ID_D_RDATA, 32'hA5A5_0300, "s5_rdata");
    expect_at(t0 + 5, ID_DRAINED, 0, "s5_drn_resp");
    expect_at(t0 + 6, ID_DRAINED, 1, "s5_drained");
    expect_at(t0 + 10, ID_MEM_REQ, 0, "s5_blocked");
    expect_at(t0 + 11, ID_DRAINED, 1, "s5_drn_hold");
    expect_at(t0 + 12, ID_DRAINED, 0, "s5_drn_drop");
    expect_at(t0 + 13, ID_MEM_ADDR, 32'h50, "s5_f_addr");
    tick(2);
    halt_req = 1'b1; if_req = 1'b1; if_addr = 32'h50;
    wait_resp(1'b1, 10);
    tick(t0 + 12 - cyc);
    halt_req = 1'b0;
    wait_resp(1'b0, 12);

    // reset during a data write, then a normal read
    tick(1);
    mem_lat = 5; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h400; d_wdata = 32'h55AA_55AA; t0 = cyc;
    expect_at(t0 + 1, ID_MEM_REQ, 1, "s6_req");
    tick(2);
    rst_n = 1'b0; d_req = 1'b0; d_we = 1'b0;
    expect_at(cyc, ID_MEM_REQ, 0, "s6_rst_req");
    expect_at(cyc, ID_MEM_WE, 0, "s6_rst_we");
    expect_at(cyc, ID_MEM_ADDR, 0, "s6_rst_addr");
    expect_at(cyc, ID_MEM_WDATA, 0, "s6_rst_wdata");
    expect_at(cyc, ID_IF_RDATA, 0, "s6_rst_if_rdata");
    expect_at(cyc, ID_D_RDATA, 0, "s6_rst_d_rdata");
    tick(2);
    rst_n = 1'b1;
    expect_at(t0 + 7, ID_D_ACK, 0, "s6_no_ack");
    tick(6);
    mem_lat = 1; d_req = 1'b1; d_addr = 32'h400; t0 = cyc;
    expect_at(t0 + 1, ID_MEM_ADDR, 32'h400, "s6_addr");
    expect_at(t0 + 3, ID_D_ACK, 1, "s6_d_ack");
    expect_at(t0 + 3, ID_D_RDATA, 32'hA5A5_0400, "s6_rdata");
    wait_resp(1'b1, 10);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=hang want=finish", cyc);
    $fatal(1, "watchdog");
  end
endmodule
